// File: rtl/ram_image_streamer.sv
// Streams the processed image out of the frame RAM in raster order, one byte
// per valid/ready handshake, tagging row ends and the final pixel.
module ram_image_streamer #(
  parameter int unsigned IMG_W  = 400,
  parameter int unsigned IMG_H  = 400,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr_read,
  output logic              ram_rden,
  input  logic [7:0]        ram_data_read,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_line_end,
  output logic              out_last
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_rden_q, ram_rden_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_line_end_q, out_line_end_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      addr_q         <= '0;
      lat_q          <= '0;
      ram_addr_q     <= '0;
      ram_rden_q     <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_line_end_q <= 1'b0;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      addr_q         <= addr_d;
      lat_q          <= lat_d;
      ram_addr_q     <= ram_addr_d;
      ram_rden_q     <= ram_rden_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_line_end_q <= out_line_end_d;
      out_last_q     <= out_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Outputs are computed one state ahead so they are valid while in the target state.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    addr_d         = addr_q;
    lat_d          = lat_q;
    ram_addr_d     = ram_addr_q;
    ram_rden_d     = 1'b0;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_line_end_d = out_line_end_q;
    out_last_d     = out_last_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        col_d      = '0;
        row_d      = '0;
        addr_d     = '0;
        ram_addr_d = '0;
        busy_d     = 1'b0;
        if (start) begin
          state_d    = S_ISSUE;
          ram_rden_d = 1'b0 | 1'b1;
          busy_d     = 1'b1;
        end
      end

      S_ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (lat_q == '0) begin
          out_data_d     = ram_data_read;
          out_valid_d    = 1'b1;
          out_line_end_d = (col_q == COL_LAST);
          out_last_d     = (col_q == COL_LAST) && (row_q == ROW_LAST);
          state_d        = S_SEND;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d    = 1'b0;
          out_line_end_d = 1'b0;
          out_last_d     = 1'b0;
          if (out_last_q) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            // Raster advance: addr tracks row*IMG_W+col without a multiplier.
            addr_d     = addr_q + ADDR_W'(1);
            ram_addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            ram_rden_d = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end

      S_FINISH: begin
        col_d      = '0;
        row_d      = '0;
        addr_d     = '0;
        ram_addr_d = '0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign ram_addr_read = ram_addr_q;
  assign ram_rden      = ram_rden_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_line_end  = out_line_end_q;
  assign out_last      = out_last_q;

endmodule
